// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register specifier type and the special specifiers.
package y86_pkg;
  localparam int         REG_RSP = 4;
  localparam logic [3:0] RNONE   = 4'hF;
  typedef logic [3:0] reg_id_t;
endpackage

// File: rtl/y86_pend_ctr.sv
// Saturating pending-writer counter for one register; err is sticky until rst.
module y86_pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        inc,
  input  logic [1:0]        dec,
  output logic [PEND_W-1:0] cnt,
  output logic              err
);
  localparam logic [PEND_W-1:0] MAX = '1;

  // Two guard bits: top bit marks a negative result, next bit marks overflow.
  logic [PEND_W+1:0] sum;
  logic              neg, ovf;

  always_comb begin
    sum = {2'b00, cnt} + {{PEND_W{1'b0}}, inc} - {{PEND_W{1'b0}}, dec};
    neg = sum[PEND_W+1];
    ovf = !neg && sum[PEND_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= neg ? '0 : (ovf ? MAX : sum[PEND_W-1:0]);
      if (neg || ovf) err <= 1'b1;
    end
  end
endmodule

// File: rtl/y86_regfile_sb.sv
// Y86-64 register file: two write ports (M beats E), two read ports with
// optional same-cycle bypass, and a per-register pending-write scoreboard.
module y86_regfile_sb
  import y86_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter int                NREGS  = 15,
  parameter int                ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RNONE  = ADDR_W'(4'hF),
  parameter int                BYPASS = 1,
  parameter int                PEND_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       srcA,
  input  logic [ADDR_W-1:0]       srcB,
  output logic [DATA_W-1:0]       valA,
  output logic [DATA_W-1:0]       valB,
  output logic                    busyA,
  output logic                    busyB,
  input  logic [ADDR_W-1:0]       dstE,
  input  logic [DATA_W-1:0]       valE,
  input  logic [ADDR_W-1:0]       dstM,
  input  logic [DATA_W-1:0]       valM,
  input  logic [ADDR_W-1:0]       issE,
  input  logic [ADDR_W-1:0]       issM,
  output logic                    sb_err,
  output logic [DATA_W-1:0]       rsp,
  output logic [NREGS*DATA_W-1:0] regs_flat
);
  logic [DATA_W-1:0] rf   [NREGS];
  logic [PEND_W-1:0] pend [NREGS];
  logic [NREGS-1:0]  err_v;

  function automatic logic ok(input logic [ADDR_W-1:0] s);
    return (s != RNONE) && (int'(s) < NREGS);
  endfunction

  // M is applied last so it wins a same-register conflict (popq %rsp).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (ok(dstE)) rf[dstE] <= valE;
      if (ok(dstM)) rf[dstM] <= valM;
    end
  end

  always_comb begin
    valA = '0;
    if (ok(srcA)) begin
      valA = rf[srcA];
      if (BYPASS != 0) begin
        if (srcA == dstM)      valA = valM;
        else if (srcA == dstE) valA = valE;
      end
    end
    valB = '0;
    if (ok(srcB)) begin
      valB = rf[srcB];
      if (BYPASS != 0) begin
        if (srcB == dstM)      valB = valM;
        else if (srcB == dstE) valB = valE;
      end
    end
  end

  // Busy comes from stored counters only; a same-cycle retire is covered by bypass.
  assign busyA  = ok(srcA) && (pend[srcA] != '0);
  assign busyB  = ok(srcB) && (pend[srcB] != '0);
  assign sb_err = |err_v;
  assign rsp    = rf[REG_RSP];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    logic [1:0] inc, dec;
    assign inc = {1'b0, ok(issE) && (issE == ADDR_W'(i))}
               + {1'b0, ok(issM) && (issM == ADDR_W'(i))};
    assign dec = {1'b0, ok(dstE) && (dstE == ADDR_W'(i))}
               + {1'b0, ok(dstM) && (dstM == ADDR_W'(i))};

    y86_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .dec (dec),
      .cnt (pend[i]),
      .err (err_v[i])
    );

    assign regs_flat[i*DATA_W +: DATA_W] = rf[i];
  end
endmodule
